// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel clock-enable, H/V position counters, sync/blank/DE decode.
// Optional macro VIDEO_TIMING_LINE_IRQ_EN adds LINE_CMP_I/LINE_IRQ_O line-compare interrupt.
module video_timing_gen #(
  parameter int CLK_DIV      = 8,
  parameter int H_W          = 9,
  parameter int V_W          = 9,
  parameter int H_ACTIVE     = 288,
  parameter int H_SYNC_START = 304,
  parameter int H_SYNC_END   = 336,
  parameter int H_TOTAL      = 384,
  parameter int V_ACTIVE     = 224,
  parameter int V_SYNC_START = 240,
  parameter int V_SYNC_END   = 243,
  parameter int V_TOTAL      = 264,
  parameter bit HSYNC_POL    = 1'b0,
  parameter bit VSYNC_POL    = 1'b0
) (
  input  logic           CLK_I,
  input  logic           RST_I,
  input  logic           HRESET_I,
`ifdef VIDEO_TIMING_LINE_IRQ_EN
  input  logic [V_W-1:0] LINE_CMP_I,
  output logic           LINE_IRQ_O,
`endif
  output logic           PIX_CE_O,
  output logic [H_W-1:0] HCOUNT_O,
  output logic [V_W-1:0] VCOUNT_O,
  output logic           HSYNC_O,
  output logic           VSYNC_O,
  output logic           HBLANK_O,
  output logic           VBLANK_O,
  output logic           DE_O,
  output logic           HRESET_O,
  output logic           VRESET_O
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("video_timing_gen: CLK_DIV must be >= 1");
  end
  if (!(H_ACTIVE < H_SYNC_START && H_SYNC_START < H_SYNC_END &&
        H_SYNC_END <= H_TOTAL && H_TOTAL <= (1 << H_W))) begin : g_bad_h
    $error("video_timing_gen: illegal horizontal timing ordering");
  end
  if (!(V_ACTIVE < V_SYNC_START && V_SYNC_START < V_SYNC_END &&
        V_SYNC_END <= V_TOTAL && V_TOTAL <= (1 << V_W))) begin : g_bad_v
    $error("video_timing_gen: illegal vertical timing ordering");
  end

  logic [DIV_W-1:0] r_div;
  logic             r_hreq;
  logic [H_W-1:0]   r_hcount;
  logic [V_W-1:0]   r_vcount;
  logic             r_pix_ce, r_hsync, r_vsync, r_hblank, r_vblank, r_de, r_hrst, r_vrst;

  logic             w_ce, w_line_start;
  logic [H_W-1:0]   w_h_nxt;
  logic [V_W-1:0]   w_v_nxt;
  logic             w_hsync_act, w_vsync_act, w_hblank, w_vblank;

  // A request raised in the same cycle as ce is honoured immediately.
  always_comb begin
    w_ce         = (r_div == DIV_LAST);
    w_line_start = (r_hcount == H_LAST) | r_hreq | HRESET_I;
    w_h_nxt      = r_hcount + 1'b1;
    w_v_nxt      = r_vcount;
    if (w_line_start) begin
      w_h_nxt = '0;
      w_v_nxt = (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
    end
    w_hblank    = (int'(w_h_nxt) >= H_ACTIVE);
    w_vblank    = (int'(w_v_nxt) >= V_ACTIVE);
    w_hsync_act = (int'(w_h_nxt) >= H_SYNC_START) && (int'(w_h_nxt) < H_SYNC_END);
    w_vsync_act = (int'(w_v_nxt) >= V_SYNC_START) && (int'(w_v_nxt) < V_SYNC_END);
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_div    <= '0;
      r_hreq   <= 1'b0;
      r_hcount <= H_LAST;
      r_vcount <= V_LAST;
      r_pix_ce <= 1'b0;
      r_hsync  <= ~HSYNC_POL;
      r_vsync  <= ~VSYNC_POL;
      r_hblank <= 1'b1;
      r_vblank <= 1'b1;
      r_de     <= 1'b0;
      r_hrst   <= 1'b0;
      r_vrst   <= 1'b0;
    end else begin
      r_div    <= w_ce ? '0 : r_div + 1'b1;
      r_pix_ce <= w_ce;
      r_hrst   <= w_ce && (w_h_nxt == '0);
      r_vrst   <= w_ce && (w_h_nxt == '0) && (w_v_nxt == '0);
      if (w_ce) begin
        r_hreq   <= 1'b0;
        r_hcount <= w_h_nxt;
        r_vcount <= w_v_nxt;
        r_hsync  <= w_hsync_act ? HSYNC_POL : ~HSYNC_POL;
        r_vsync  <= w_vsync_act ? VSYNC_POL : ~VSYNC_POL;
        r_hblank <= w_hblank;
        r_vblank <= w_vblank;
        r_de     <= ~w_hblank & ~w_vblank;
      end else if (HRESET_I) begin
        r_hreq <= 1'b1;
      end
    end
  end

`ifdef VIDEO_TIMING_LINE_IRQ_EN
  logic r_line_irq;
  // Counters never exceed V_TOTAL-1, so an out-of-range compare value never matches.
  always_ff @(posedge CLK_I) begin
    if (RST_I) r_line_irq <= 1'b0;
    else       r_line_irq <= w_ce && (w_h_nxt == '0) && (w_v_nxt == LINE_CMP_I);
  end
  assign LINE_IRQ_O = r_line_irq;
`endif

  assign PIX_CE_O = r_pix_ce;
  assign HCOUNT_O = r_hcount;
  assign VCOUNT_O = r_vcount;
  assign HSYNC_O  = r_hsync;
  assign VSYNC_O  = r_vsync;
  assign HBLANK_O = r_hblank;
  assign VBLANK_O = r_vblank;
  assign DE_O     = r_de;
  assign HRESET_O = r_hrst;
  assign VRESET_O = r_vrst;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default-geometry instance A plus a tiny CLK_DIV=1 instance B.
module tb_video_timing_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_hrst_i = 1'b0;
  logic b_hrst_i = 1'b0;
  always #5 clk = ~clk;

  logic       a_pce, a_hs, a_vs, a_hb, a_vb, a_de, a_hr, a_vr;
  logic [8:0] a_h, a_v;
  logic       b_pce, b_hs, b_vs, b_hb, b_vb, b_de, b_hr, b_vr;
  logic [3:0] b_h;
  logic [1:0] b_v;
  logic       b_irq_bit;
`ifdef VIDEO_TIMING_LINE_IRQ_EN
  logic [8:0] a_cmp = 9'd1;
  logic [1:0] b_cmp = 2'd2;
  logic       a_irq, b_irq;
  int         a_irq_n = 0;
  always @(negedge clk) if (a_irq) a_irq_n++;
  assign b_irq_bit = b_irq;
`else
  assign b_irq_bit = 1'b0;
`endif

  video_timing_gen u_a (
    .CLK_I(clk), .RST_I(rst), .HRESET_I(a_hrst_i),
`ifdef VIDEO_TIMING_LINE_IRQ_EN
    .LINE_CMP_I(a_cmp), .LINE_IRQ_O(a_irq),
`endif
    .PIX_CE_O(a_pce), .HCOUNT_O(a_h), .VCOUNT_O(a_v), .HSYNC_O(a_hs), .VSYNC_O(a_vs),
    .HBLANK_O(a_hb), .VBLANK_O(a_vb), .DE_O(a_de), .HRESET_O(a_hr), .VRESET_O(a_vr)
  );

  video_timing_gen #(
    .CLK_DIV(1), .H_W(4), .V_W(2),
    .H_ACTIVE(10), .H_SYNC_START(11), .H_SYNC_END(14), .H_TOTAL(16),
    .V_ACTIVE(1), .V_SYNC_START(2), .V_SYNC_END(3), .V_TOTAL(4),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
  ) u_b (
    .CLK_I(clk), .RST_I(rst), .HRESET_I(b_hrst_i),
`ifdef VIDEO_TIMING_LINE_IRQ_EN
    .LINE_CMP_I(b_cmp), .LINE_IRQ_O(b_irq),
`endif
    .PIX_CE_O(b_pce), .HCOUNT_O(b_h), .VCOUNT_O(b_v), .HSYNC_O(b_hs), .VSYNC_O(b_vs),
    .HBLANK_O(b_hb), .VBLANK_O(b_vb), .DE_O(b_de), .HRESET_O(b_hr), .VRESET_O(b_vr)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_a(input int h, input int v);
    int n = 0;
    while (!(a_h == h && a_v == v) && n < 40000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40000) begin
      tests++;
      fails++;
      $display("FAIL wait_pos(%0d,%0d): timed out at (%0d,%0d)", h, v, a_h, a_v);
    end
  endtask

  task automatic wait_ce();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_pce && n < 32);
    if (!a_pce) begin
      tests++;
      fails++;
      $display("FAIL wait_ce: no PIX_CE_O within %0d clocks", n);
    end
  endtask

  typedef struct {
    int   h;
    logic hb;
    logic hs;
    logic de;
  } vec_t;
  vec_t tbl[8];

  int   bh, bv, b_vr_n, b_last_vr, b_period;
  logic b_irq_exp;
  logic [15:0] b_exp;

  initial begin
    tbl[0] = '{0,   1'b0, 1'b1, 1'b1};
    tbl[1] = '{287, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{288, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{303, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{304, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{335, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{336, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{383, 1'b1, 1'b1, 1'b0};

    // Reset state after three reset clocks
    repeat (3) @(negedge clk);
    chk("a_reset_pos", {a_h, a_v}, {9'd383, 9'd263});
    chk("a_reset_flags", {a_pce, a_hs, a_vs, a_hb, a_vb, a_de, a_hr, a_vr}, 8'b0111_1000);
    chk("b_reset", {b_pce, b_h, b_v, b_hs, b_vs, b_hb, b_vb, b_de, b_hr, b_vr},
        {1'b0, 4'd15, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
`ifdef VIDEO_TIMING_LINE_IRQ_EN
    chk("irq_in_reset", {a_irq, b_irq}, 2'b00);
`endif
    rst = 1'b0;

    bh = 15; bv = 3; b_vr_n = 0; b_last_vr = 0; b_period = 0;
    for (int cyc = 1; cyc <= 140; cyc++) begin
      @(negedge clk);
      chk($sformatf("a_pce cyc%0d", cyc), a_pce, (cyc % 8 == 0));
      if (cyc == 7) chk("a_before_first_ce", {a_h, a_v, a_hr, a_vr}, {9'd383, 9'd263, 2'b00});
      if (cyc == 8) chk("a_first_ce", {a_h, a_v, a_hr, a_vr}, {9'd0, 9'd0, 2'b11});
      if (cyc == 9) chk("a_pulses_clear", {a_h, a_v, a_hr, a_vr}, {9'd0, 9'd0, 2'b00});
      if (bh == 15) begin
        bh = 0;
        bv = (bv + 1) % 4;
      end else begin
        bh++;
      end
`ifdef VIDEO_TIMING_LINE_IRQ_EN
      b_irq_exp = (bh == 0 && bv == 2);
`else
      b_irq_exp = 1'b0;
`endif
      b_exp = {1'b1, 4'(bh), 2'(bv), (bh >= 11 && bh < 14), !(bv == 2), (bh >= 10), (bv >= 1),
               (bh < 10 && bv < 1), (bh == 0), (bh == 0 && bv == 0), b_irq_exp};
      chk($sformatf("b_model cyc%0d", cyc),
          {b_pce, b_h, b_v, b_hs, b_vs, b_hb, b_vb, b_de, b_hr, b_vr, b_irq_bit}, b_exp);
      if (b_vr) begin
        b_vr_n++;
        if (b_last_vr != 0) b_period = cyc - b_last_vr;
        b_last_vr = cyc;
      end
    end
    chk("b_vreset_count", b_vr_n, 3);
    chk("b_frame_clocks", b_period, 64);

    // Line 1 entry and line decode on the default geometry
    wait_a(0, 1);
    chk("a_line1_entry", {a_hr, a_vr, a_pce}, 3'b101);
`ifdef VIDEO_TIMING_LINE_IRQ_EN
    chk("a_irq_line1", a_irq, 1'b1);
`endif
    foreach (tbl[i]) begin
      wait_a(tbl[i].h, 1);
      chk($sformatf("decode h=%0d", tbl[i].h), {a_hb, a_hs, a_de, a_vb, a_vs},
          {tbl[i].hb, tbl[i].hs, tbl[i].de, 1'b0, 1'b1});
    end

    // Forced line start mid-line
`ifdef VIDEO_TIMING_LINE_IRQ_EN
    a_cmp = 9'd6;
`endif
    wait_a(100, 5);
    a_hrst_i = 1'b1;
    @(negedge clk);
    a_hrst_i = 1'b0;
    wait_ce();
    chk("hreset_mid", {a_h, a_v, a_hr, a_vr}, {9'd0, 9'd6, 2'b10});
`ifdef VIDEO_TIMING_LINE_IRQ_EN
    chk("a_irq_forced_line", a_irq, 1'b1);
    a_cmp = 9'd300;
    @(negedge clk);
    a_irq_n = 0;
`endif

    // Forced line start coinciding with the natural wrap
    wait_a(383, 6);
    a_hrst_i = 1'b1;
    @(negedge clk);
    a_hrst_i = 1'b0;
    wait_ce();
    chk("hreset_at_wrap", {a_h, a_v, a_hr}, {9'd0, 9'd7, 1'b1});
    wait_ce();
    chk("after_wrap_single", {a_h, a_v, a_hr}, {9'd1, 9'd7, 1'b0});

    // Reset mid-line for a single clock, with HRESET_I also high
    wait_a(200, 8);
    rst = 1'b1;
    a_hrst_i = 1'b1;
    @(negedge clk);
    chk("midline_reset_pos", {a_h, a_v}, {9'd383, 9'd263});
    chk("midline_reset_flags", {a_pce, a_hs, a_vs, a_hb, a_vb, a_de, a_hr, a_vr}, 8'b0111_1000);
    rst = 1'b0;
    a_hrst_i = 1'b0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      chk($sformatf("post_reset pce cyc%0d", cyc), a_pce, (cyc % 8 == 0));
      if (cyc == 7) chk("post_reset_hold", {a_h, a_v, a_hr, a_vr}, {9'd383, 9'd263, 2'b00});
      if (cyc == 8) chk("post_reset_first_ce", {a_h, a_v, a_hr, a_vr, a_de}, {9'd0, 9'd0, 3'b111});
      if (cyc == 16) chk("post_reset_second_ce", {a_h, a_v, a_hr, a_vr}, {9'd1, 9'd0, 2'b00});
    end
`ifdef VIDEO_TIMING_LINE_IRQ_EN
    chk("a_irq_out_of_range", a_irq_n, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
